// File: rtl/mips_div_unit.sv
// -----------------------------------------------------------------------------
// mips_div_unit
//
// Multi-cycle radix-2 restoring divider for the MIPS datapath (DIV / DIVU).
// Produces the quotient (LO) and remainder (HI) after WIDTH+1 cycles.
//
// Configuration macro:
//   DIV_EARLY_OUT_EN  - when defined, a zero divisor or |dividend| < |divisor|
//                       skips the iteration phase and finishes 1 cycle after
//                       start.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request, sampled only while idle
//   is_signed    1 = DIV (two's complement), 0 = DIVU; sampled with start
//   dividend     rs operand; sampled with start
//   divisor      rt operand; sampled with start
//   busy         high from the cycle after an accepted start through done
//   done         one-cycle pulse; results valid from this cycle onward
//   quotient     LO result, held until the next done
//   remainder    HI result, held until the next done
//   div_by_zero  set with done when the divisor was 0; held with the results
// -----------------------------------------------------------------------------
module mips_div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;

  logic [WIDTH-1:0]   rem_q;       // partial remainder
  logic [WIDTH-1:0]   dq_q;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   dsr_q;       // divisor magnitude
  logic [CNT_W-1:0]   count_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               dvz_q;

  logic               dividend_neg;
  logic               divisor_neg;
  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic               early_out;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic               trial_ok;

  // ---------------------------------------------------------------------------
  // Operand conditioning and one restoring step
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    dividend_neg = is_signed & dividend[WIDTH-1];
    divisor_neg  = is_signed & divisor[WIDTH-1];
    dividend_mag = dividend_neg ? -dividend : dividend;
    divisor_mag  = divisor_neg  ? -divisor  : divisor;

`ifdef DIV_EARLY_OUT_EN
    early_out = (divisor_mag == '0) || (dividend_mag < divisor_mag);
`else
    early_out = 1'b0;
`endif

    // The partial remainder is always below the divisor, so the shifted value
    // needs one extra bit and a non-negative trial always fits back in WIDTH.
    shifted  = {rem_q, dq_q[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    trial_ok = ~trial[WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = early_out ? S_FIX : S_RUN;
      S_RUN:  if (count_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q       <= '0;
      dq_q        <= '0;
      dsr_q       <= '0;
      count_q     <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dvz_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      // busy also covers the done cycle, where the FSM is already idle.
      busy <= (state_d != S_IDLE) || (state_q == S_FIX);

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            // Early-out leaves the quotient at zero and the whole dividend
            // magnitude as the remainder.
            rem_q     <= early_out ? dividend_mag : '0;
            dq_q      <= early_out ? '0 : dividend_mag;
            dsr_q     <= divisor_mag;
            count_q   <= CNT_W'(WIDTH);
            neg_quo_q <= dividend_neg ^ divisor_neg;
            neg_rem_q <= dividend_neg;
            dvz_q     <= (divisor == '0);
          end
        end

        S_RUN: begin
          rem_q   <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          dq_q    <= {dq_q[WIDTH-2:0], trial_ok};
          count_q <= count_q - CNT_W'(1);
        end

        S_FIX: begin
          done        <= 1'b1;
          div_by_zero <= dvz_q;
          // With a zero divisor every trial succeeds, so rem_q ends up equal
          // to the dividend magnitude; re-applying the dividend sign restores
          // the original dividend bits. Only the quotient needs overriding.
          quotient    <= dvz_q ? '1 : (neg_quo_q ? -dq_q : dq_q);
          remainder   <= neg_rem_q ? -rem_q : rem_q;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_div_unit
//
// Directed-vector bench for mips_div_unit: a WIDTH=32 instance for the main
// vectors and control boundaries, plus a WIDTH=8 instance for the narrow case.
// -----------------------------------------------------------------------------
module tb_mips_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  logic        start8;
  logic        is_signed8;
  logic [7:0]  dividend8;
  logic [7:0]  divisor8;
  logic        busy8;
  logic        done8;
  logic [7:0]  quotient8;
  logic [7:0]  remainder8;
  logic        div_by_zero8;

  int checks;
  int failures;

  mips_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  mips_div_unit #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .start       (start8),
    .is_signed   (is_signed8),
    .dividend    (dividend8),
    .divisor     (divisor8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (quotient8),
    .remainder   (remainder8),
    .div_by_zero (div_by_zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is seen at the next posedge (E0) and the task
  // returns at the negedge that follows.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Counts posedges from E0 until done is seen at a negedge (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!done && lat < 100);
  endtask

  task automatic run_op(input string tag, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int elat);
    int lat;
    launch(s, a, b);
    check({tag, "_busy_run"}, 64'(busy), 64'(1));
    wait_done(lat);
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_q"}, 64'(quotient), 64'(eq));
    check({tag, "_r"}, 64'(remainder), 64'(er));
    check({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
    check({tag, "_busy_done"}, 64'(busy), 64'(1));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
    check({tag, "_q_held"}, 64'(quotient), 64'(eq));
  endtask

  initial begin
    int lat;
    int pulses;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    start      = 1'b0;
    is_signed  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    start8     = 1'b0;
    is_signed8 = 1'b0;
    dividend8  = '0;
    divisor8   = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_q", 64'(quotient), 64'(0));
    check("rst_r", 64'(remainder), 64'(0));
    check("rst_dz", 64'(div_by_zero), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    run_op("u100_7",   1'b0, 32'd100,      32'd7,        32'h0000_000E, 32'h0000_0002, 1'b0, 33);
    run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("s_7_m2",   1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 33);
    run_op("s_dz",     1'b1, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, DZ_LAT);
    run_op("u_dz",     1'b0, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, DZ_LAT);
    run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 33);

    // WIDTH=8: 200 / 3 unsigned -> 66 r 2, done WIDTH+1 = 9 cycles after start.
    is_signed8 = 1'b0;
    dividend8  = 8'd200;
    divisor8   = 8'd3;
    start8     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!done8 && lat < 100);
    check("w8_latency", 64'(lat), 64'(9));
    check("w8_q", 64'(quotient8), 64'(8'h42));
    check("w8_r", 64'(remainder8), 64'(8'h02));
    check("w8_dz", 64'(div_by_zero8), 64'(0));

    // A second start while busy is ignored.
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ign_done_seen", 64'(done), 64'(1));
    check("ign_q", 64'(quotient), 64'(32'h0000_000E));
    check("ign_r", 64'(remainder), 64'(32'h0000_0002));
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("ign_no_second", 64'(pulses), 64'(0));
    check("ign_busy", 64'(busy), 64'(0));

    // Reset during the 10th RUN cycle aborts immediately.
    launch(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_q", 64'(quotient), 64'(0));
    check("abort_r", 64'(remainder), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'(0));

    // start in the done cycle is accepted; next done 33 cycles later.
    launch(1'b0, 32'd100, 32'd7);
    wait_done(lat);
    check("b2b_first_q", 64'(quotient), 64'(32'h0000_000E));
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'(1));
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'(33));
    check("b2b_q", 64'(quotient), 64'(32'd100));
    check("b2b_r", 64'(remainder), 64'(32'd0));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
